// File: rtl/mac_accumulator.sv
// -----------------------------------------------------------------------------
// mac_accumulator
//
// Accumulation stage behind the NPU MAC multiplier. It sums a stream of
// unsigned products into a saturating accumulator. The accumulator adder is
// built from 4-bit carry-look-ahead slices, with the carry rippling from one
// slice to the next. When a term is flagged last, the result is presented
// through a valid/ready handshake. Once the result is taken, the stage
// restarts for the next vector.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   product on in_prod is valid
//   in_ready   stage can accept a product this cycle (registered)
//   in_prod    unsigned product, PROD_W bits
//   in_last    marks in_prod as the final term of the vector
//   out_valid  result on out_acc/out_ovf/out_cnt is valid (registered)
//   out_ready  downstream accepts the result
//   out_acc    saturated accumulated sum, ACC_W bits
//   out_ovf    sticky flag: saturation occurred during this vector
//   out_cnt    number of terms accepted, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module mac_accumulator #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic              out_ovf,
    output logic [CNT_W-1:0]  out_cnt
);

    localparam int NUM_SLICES = ACC_W / 4;

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W-1:0]   out_acc_q, out_acc_d;
    logic               out_ovf_q, out_ovf_d;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;

    logic [ACC_W-1:0]   addend;
    logic [ACC_W-1:0]   sum_raw;
    logic               carry_out;

    // This function is one 4-bit look-ahead slice. It returns {carry_out, sum[3:0]}.
    // Every carry is computed directly from the generate/propagate terms
    // and the slice carry-in, with no ripple inside the slice.
    function automatic logic [4:0] cla4(input logic [3:0] a,
                                        input logic [3:0] b,
                                        input logic       cin);
        logic [3:0] p;
        logic [3:0] g;
        logic [3:0] c;
        logic       cout;
        p    = a ^ b;
        g    = a & b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
        return {cout, p ^ c};
    endfunction

    assign addend = ACC_W'(in_prod);

    // Chain the slices. Slice 0 has a carry-in of 0. Each later slice takes
    // the carry-out of the slice below it.
    always_comb begin
        logic       c;
        logic [4:0] slice_res;
        c         = 1'b0;
        sum_raw   = '0;
        slice_res = '0;
        for (int i = 0; i < NUM_SLICES; i++) begin
            slice_res          = cla4(acc_q[4*i +: 4], addend[4*i +: 4], c);
            sum_raw[4*i +: 4]  = slice_res[3:0];
            c                  = slice_res[4];
        end
        carry_out = c;
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        cnt_d       = cnt_q;
        out_acc_d   = out_acc_q;
        out_ovf_d   = out_ovf_q;
        out_cnt_d   = out_cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        case (state_q)
            ACCUM: begin
                if (in_valid) begin
                    // A carry out of the top slice pins the sum at all-ones.
                    // Once the sum is all-ones, any nonzero addend carries
                    // again, so the saturation holds for the rest of the vector.
                    acc_d = carry_out ? '1 : sum_raw;
                    ovf_d = ovf_q | carry_out;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (in_last) begin
                        state_d     = DONE;
                        out_acc_d   = acc_d;
                        out_ovf_d   = ovf_d;
                        out_cnt_d   = cnt_d;
                        in_ready_d  = 1'b0;
                        out_valid_d = 1'b1;
                    end
                end
            end
            DONE: begin
                // The result registers are left alone here. They stay valid
                // until the next vector finishes or a reset occurs.
                if (out_ready) begin
                    state_d     = ACCUM;
                    acc_d       = '0;
                    ovf_d       = 1'b0;
                    cnt_d       = '0;
                    in_ready_d  = 1'b1;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = ACCUM;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
            out_acc_q   <= '0;
            out_ovf_q   <= 1'b0;
            out_cnt_q   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
            out_acc_q   <= out_acc_d;
            out_ovf_q   <= out_ovf_d;
            out_cnt_q   <= out_cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_acc   = out_acc_q;
    assign out_ovf   = out_ovf_q;
    assign out_cnt   = out_cnt_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// -----------------------------------------------------------------------------
// tb_mac_accumulator
//
// Self-checking bench for mac_accumulator with the default parameters.
// It runs the directed scenarios first and then randomized vectors. The
// reference model is kept as a plain integer sum and a term count: the
// expected result is min(sum, 2^16-1), the overflow flag is sum > 2^16-1,
// and the count is the number of terms mod 256.
// -----------------------------------------------------------------------------
module tb_mac_accumulator;

    localparam int PROD_W = 8;
    localparam int ACC_W  = 16;
    localparam int CNT_W  = 8;
    localparam longint ACC_MAX = (64'd1 << ACC_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_acc;
    logic              out_ovf;
    logic [CNT_W-1:0]  out_cnt;

    mac_accumulator #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_ovf   (out_ovf),
        .out_cnt   (out_cnt)
    );

    always #5 clk = ~clk;

    int     n_checks = 0;
    int     n_fail   = 0;
    longint m_sum    = 0;
    int     m_n      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Advance one clock and settle 1 ns past the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_acc();
        return (m_sum > ACC_MAX) ? 32'(ACC_MAX) : 32'(m_sum);
    endfunction

    function automatic logic [31:0] exp_ovf();
        return (m_sum > ACC_MAX) ? 32'd1 : 32'd0;
    endfunction

    function automatic logic [31:0] exp_cnt();
        return 32'(m_n % (1 << CNT_W));
    endfunction

    // Optionally insert idle cycles first. During them in_last and out_ready
    // take random values to show they have no effect. Then present one term
    // and hold it until it is accepted.
    task automatic send(input logic [PROD_W-1:0] p, input bit last, input int gap);
        int guard;
        repeat (gap) begin
            in_valid  = 1'b0;
            in_last   = 1'($urandom_range(0, 1));
            in_prod   = PROD_W'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            step();
        end
        in_valid  = 1'b1;
        in_prod   = p;
        in_last   = last;
        out_ready = 1'($urandom_range(0, 1));
        guard = 0;
        while (!in_ready && guard < 100) begin
            step();
            guard++;
        end
        if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
        step();
        m_sum += longint'(p);
        m_n++;
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!last) check("mid_vector_out_valid", 32'(out_valid), 32'd0);
    endtask

    // Call this right after the last term is accepted. It checks the result,
    // stalls for the given number of cycles, then completes the handshake.
    task automatic expect_result(input string tag, input int stall);
        logic [31:0] e_acc;
        logic [31:0] e_ovf;
        logic [31:0] e_cnt;
        e_acc = exp_acc();
        e_ovf = exp_ovf();
        e_cnt = exp_cnt();
        check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        check({tag, ".in_ready"},  32'(in_ready),  32'd0);
        check({tag, ".out_acc"},   32'(out_acc),   e_acc);
        check({tag, ".out_ovf"},   32'(out_ovf),   e_ovf);
        check({tag, ".out_cnt"},   32'(out_cnt),   e_cnt);
        $display("vector %s: acc=%0d ovf=%0d cnt=%0d (expected acc=%0d ovf=%0d cnt=%0d)",
                 tag, out_acc, out_ovf, out_cnt, e_acc, e_ovf, e_cnt);
        out_ready = 1'b0;
        repeat (stall) begin
            step();
            check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, ".hold_ready"}, 32'(in_ready),  32'd0);
            check({tag, ".hold_acc"},   32'(out_acc),   e_acc);
            check({tag, ".hold_ovf"},   32'(out_ovf),   e_ovf);
            check({tag, ".hold_cnt"},   32'(out_cnt),   e_cnt);
        end
        out_ready = 1'b1;
        step();
        check({tag, ".post_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".post_ready"}, 32'(in_ready),  32'd1);
        out_ready = 1'b0;
        m_sum = 0;
        m_n   = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".in_ready"},  32'(in_ready),  32'd1);
        check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".out_acc"},   32'(out_acc),   32'd0);
        check({tag, ".out_ovf"},   32'(out_ovf),   32'd0);
        check({tag, ".out_cnt"},   32'(out_cnt),   32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_prod   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #23;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        step();

        // Basic three-term vector. in_ready is back two cycles after the last term.
        send(8'd3, 1'b0, 0);
        send(8'd5, 1'b0, 0);
        send(8'd7, 1'b1, 0);
        expect_result("basic_3_5_7", 0);

        // 257 x 255 = 65535: the sum reaches the top exactly without overflow.
        for (int i = 0; i < 257; i++) send(8'd255, (i == 256), 0);
        expect_result("exact_full", 0);

        // 258 x 255 overflows; the extra 1 leaves the sum saturated.
        for (int i = 0; i < 258; i++) send(8'd255, 1'b0, 0);
        send(8'd1, 1'b1, 0);
        expect_result("saturate", 0);

        // Stall in DONE while a product of 9 is waiting. The 9 must not be
        // consumed until in_ready rises again.
        send(8'd11, 1'b1, 0);
        in_valid = 1'b1;
        in_prod  = 8'd9;
        in_last  = 1'b1;
        expect_result("stall_hold", 5);
        send(8'd9, 1'b1, 0);
        expect_result("held_nine", 0);

        // A single-term vector, and a vector with an idle gap between terms.
        send(8'd200, 1'b1, 0);
        expect_result("single_200", 0);
        send(8'd10, 1'b0, 0);
        send(8'd20, 1'b1, 1);
        expect_result("gap_10_20", 0);

        // Asynchronous reset while DONE: the outputs clear without a clock edge.
        send(8'd50, 1'b1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset_done");
        #3;
        rst_n = 1'b1;
        m_sum = 0;
        m_n   = 0;
        step();

        // Asynchronous reset in the middle of a vector discards the partial sum.
        send(8'd4, 1'b0, 0);
        send(8'd4, 1'b0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset_mid");
        #3;
        rst_n = 1'b1;
        m_sum = 0;
        m_n   = 0;
        step();
        send(8'd6, 1'b1, 0);
        expect_result("after_reset_6", 0);

        // Randomized vectors. Every eighth one is long enough that it may overflow.
        for (int v = 0; v < 32; v++) begin
            int len;
            len = (v % 8 == 7) ? int'($urandom_range(200, 320)) : int'($urandom_range(1, 12));
            for (int t = 0; t < len; t++)
                send(PROD_W'($urandom), (t == len - 1), int'($urandom_range(0, 2)));
            expect_result($sformatf("rand_%0d", v), int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
